// File: rtl/mantis_pkg.sv
// Shared types and sprite geometry for the mantis attack animation.
package mantis_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, DONE} seq_state_t;

    localparam int MANTIS_W             = 196;
    localparam int MANTIS_H             = 96;
    localparam int MANTIS_ADDR_W        = 15;
    localparam int MANTIS_ATTACK_FRAMES = 3;

endpackage

// File: rtl/mantis_attack_sequencer_sprite_addr_gen.sv
// Registered sprite-local ROM address and box test for a sprite at (pos_x, pos_y).
module sprite_addr_gen #(
    parameter int SPR_W  = 196,
    parameter int SPR_H  = 96,
    parameter int ADDR_W = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [9:0]        i_draw_x,
    input  logic [9:0]        i_draw_y,
    input  logic [9:0]        i_pos_x,
    input  logic [9:0]        i_pos_y,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_sprite
);

    logic signed [10:0] w_lx;
    logic signed [10:0] w_ly;
    logic [9:0]         w_ux;
    logic [9:0]         w_uy;
    logic               w_in;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_in;

    // Positions are signed so a sprite can hang off the left/top edge.
    assign w_lx = $signed({1'b0, i_draw_x}) - $signed({i_pos_x[9], i_pos_x});
    assign w_ly = $signed({1'b0, i_draw_y}) - $signed({i_pos_y[9], i_pos_y});
    assign w_ux = w_lx[9:0];
    assign w_uy = w_ly[9:0];
    assign w_in = !w_lx[10] && (int'(w_ux) < SPR_W) &&
                  !w_ly[10] && (int'(w_uy) < SPR_H);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr <= '0;
            r_in   <= 1'b0;
        end else begin
            r_in   <= w_in;
            r_addr <= w_in ? ADDR_W'(int'(w_uy) * SPR_W + int'(w_ux)) : '0;
        end
    end

    assign o_addr      = r_addr;
    assign o_in_sprite = r_in;

endmodule

// File: rtl/mantis_attack_sequencer.sv
// Steps through the attack frame ROMs on frame_tick and drives the selected ROM's pixel address.
module mantis_attack_sequencer
    import mantis_pkg::*;
#(
    parameter int NUM_FRAMES = MANTIS_ATTACK_FRAMES,
    parameter int FRAME_HOLD = 6,
    parameter int SPR_W      = MANTIS_W,
    parameter int SPR_H      = MANTIS_H,
    parameter int ADDR_W     = MANTIS_ADDR_W,
    localparam int IDX_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int HOLD_W    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    input  logic              start,
    input  logic              loop,
    input  logic              abort,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  frame_idx,
    output logic [ADDR_W-1:0] rom_address,
    output logic              in_sprite
);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [IDX_W-1:0]  r_frame_idx;
    logic              r_loop;
    logic              w_hold_end;
    logic              w_last_frame;

    assign w_hold_end   = frame_tick && (r_hold_cnt == HOLD_W'(FRAME_HOLD - 1));
    assign w_last_frame = (r_frame_idx == IDX_W'(NUM_FRAMES - 1));

    always_ff @(posedge vga_clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start && !abort) w_next = PLAY;
            PLAY: begin
                if (abort)
                    w_next = IDLE;
                else if (w_hold_end && w_last_frame && !r_loop)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == PLAY);
        done = (r_state == DONE);
    end

    // The tick that coincides with start is dropped because IDLE ignores frame_tick.
    always_ff @(posedge vga_clk) begin
        if (!reset_n || abort) begin
            r_hold_cnt  <= '0;
            r_frame_idx <= '0;
            r_loop      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_hold_cnt  <= '0;
                    r_frame_idx <= '0;
                    r_loop      <= loop;
                end
                PLAY: if (frame_tick) begin
                    if (!w_hold_end) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end else begin
                        r_hold_cnt <= '0;
                        if (!w_last_frame)
                            r_frame_idx <= r_frame_idx + 1'b1;
                        else if (r_loop)
                            r_frame_idx <= '0;
                    end
                end
                default: begin
                    r_hold_cnt  <= '0;
                    r_frame_idx <= '0;
                end
            endcase
        end
    end

    assign frame_idx = r_frame_idx;

    sprite_addr_gen #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_clk       (vga_clk),
        .i_rst_n     (reset_n),
        .i_draw_x    (DrawX),
        .i_draw_y    (DrawY),
        .i_pos_x     (pos_x),
        .i_pos_y     (pos_y),
        .o_addr      (rom_address),
        .o_in_sprite (in_sprite)
    );

endmodule

// File: tb/tb_mantis_attack_sequencer.sv
// Directed bench for the mantis attack sequencer with a tick-counting reference model.
module tb_mantis_attack_sequencer;

    localparam int NF = 3;
    localparam int FH = 2;
    localparam int W  = 196;
    localparam int H  = 96;
    localparam int AW = 15;

    logic          vga_clk = 1'b0;
    logic          reset_n, frame_tick, start, loop, abort;
    logic [9:0]    DrawX, DrawY, pos_x, pos_y;
    logic          busy, done, in_sprite;
    logic [1:0]    frame_idx;
    logic [AW-1:0] rom_address;

    int n_vec = 0;
    int n_err = 0;

    // reference model state: playback expressed as ticks counted since start
    bit m_active, m_loop, m_done;
    int m_ticks;
    int m_addr;
    bit m_in;

    mantis_attack_sequencer #(
        .NUM_FRAMES (NF), .FRAME_HOLD (FH), .SPR_W (W), .SPR_H (H), .ADDR_W (AW)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .start       (start),
        .loop        (loop),
        .abort       (abort),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .busy        (busy),
        .done        (done),
        .frame_idx   (frame_idx),
        .rom_address (rom_address),
        .in_sprite   (in_sprite)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_idx();
        if (m_active) return m_loop ? (m_ticks / FH) % NF : m_ticks / FH;
        if (m_done)   return NF - 1;
        return 0;
    endfunction

    task automatic model_edge();
        int px, py, lx, ly;
        px = (pos_x >= 512) ? int'(pos_x) - 1024 : int'(pos_x);
        py = (pos_y >= 512) ? int'(pos_y) - 1024 : int'(pos_y);
        lx = int'(DrawX) - px;
        ly = int'(DrawY) - py;
        if (!reset_n) begin
            m_addr = 0; m_in = 0;
        end else begin
            m_in   = (lx >= 0 && lx < W && ly >= 0 && ly < H);
            m_addr = m_in ? ly * W + lx : 0;
        end
        if (!reset_n || abort) begin
            m_active = 0; m_done = 0; m_ticks = 0; m_loop = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (frame_tick) begin
                m_ticks++;
                if (!m_loop && m_ticks == NF * FH) begin
                    m_active = 0; m_done = 1;
                end
            end
        end else if (start) begin
            m_active = 1; m_ticks = 0; m_loop = loop;
        end
    endtask

    // one clock: model follows the edge, outputs are compared 1 time unit later
    task automatic step();
        @(posedge vga_clk);
        model_edge();
        #1;
        chk("busy",      busy,        m_active);
        chk("done",      done,        m_done);
        chk("frame_idx", frame_idx,   exp_idx());
        chk("rom_addr",  rom_address, m_addr);
        chk("in_sprite", in_sprite,   m_in);
    endtask

    task automatic tick();
        frame_tick = 1; step(); frame_tick = 0; step();
    endtask

    task automatic tick_only();
        frame_tick = 1; step(); frame_tick = 0;
    endtask

    initial begin
        reset_n = 0; frame_tick = 0; start = 0; loop = 0; abort = 0;
        DrawX = 0; DrawY = 0; pos_x = 100; pos_y = 50;
        m_active = 0; m_loop = 0; m_done = 0; m_ticks = 0; m_addr = 0; m_in = 0;
        step(); step();
        chk("rst_busy_lit", busy, 0);
        chk("rst_idx_lit", frame_idx, 0);
        reset_n = 1; step();

        // basic non-looping playback
        start = 1; step(); start = 0;
        chk("start_busy_lit", busy, 1);
        for (int t = 1; t <= 6; t++) begin
            tick_only();
            if (t == 2) chk("idx_after_t2_lit", frame_idx, 1);
            if (t == 4) chk("idx_after_t4_lit", frame_idx, 2);
            if (t == 5) chk("no_done_t5_lit", done, 0);
            if (t == 6) begin
                chk("done_lit", done, 1);
                chk("done_busy_lit", busy, 0);
                chk("done_idx_lit", frame_idx, 2);
            end
            step();
        end
        chk("idle_after_done_lit", done, 0);
        step();

        // looping playback then abort
        start = 1; loop = 1; step(); start = 0; loop = 0;
        for (int t = 1; t <= 8; t++) begin
            tick_only();
            if (t == 6) chk("loop_wrap_lit", frame_idx, 0);
            step();
        end
        chk("loop_idx8_lit", frame_idx, 1);
        abort = 1; step(); abort = 0;
        chk("abort_busy_lit", busy, 0);
        step();

        // start and abort together
        start = 1; abort = 1; step(); start = 0; abort = 0;
        chk("start_abort_lit", busy, 0);
        step();

        // start with tick: that tick is dropped
        start = 1; frame_tick = 1; step(); start = 0; frame_tick = 0;
        for (int t = 1; t <= 6; t++) begin
            tick_only();
            if (t == 5) chk("st_tick_t5_lit", done, 0);
            if (t == 6) chk("st_tick_t6_lit", done, 1);
            step();
        end
        step();

        // start during PLAY is ignored
        start = 1; step(); start = 0;
        tick();
        start = 1; step(); step(); start = 0;
        tick();
        chk("restart_ignored_lit", frame_idx, 1);
        abort = 1; step(); abort = 0; step();

        // address mapping
        pos_x = 100; pos_y = 50;
        DrawX = 100; DrawY = 50;  step();
        chk("addr_origin_lit", rom_address, 0); chk("in_origin_lit", in_sprite, 1);
        DrawX = 295; DrawY = 145; step();
        chk("addr_corner_lit", rom_address, 18815);
        DrawX = 296; DrawY = 50;  step();
        chk("in_right_lit", in_sprite, 0); chk("addr_right_lit", rom_address, 0);
        DrawX = 99;  DrawY = 50;  step();
        chk("in_left_lit", in_sprite, 0);
        DrawX = 150; DrawY = 146; step();
        DrawX = 150; DrawY = 49;  step();
        DrawX = 200; DrawY = 100; step();
        chk("addr_mid_lit", rom_address, 50 * 196 + 100);

        // sprite partly off the left edge
        pos_x = 10'd1020; pos_y = 0; DrawX = 0; DrawY = 0; step();
        chk("neg_addr_lit", rom_address, 4); chk("neg_in_lit", in_sprite, 1);
        DrawX = 192; DrawY = 95; step();
        DrawX = 191; DrawY = 95; step();

        // reset mid-playback at frame 1
        pos_x = 100; pos_y = 50; DrawX = 120; DrawY = 60;
        start = 1; step(); start = 0;
        tick(); tick();
        chk("pre_rst_idx_lit", frame_idx, 1);
        reset_n = 0; step(); reset_n = 1;
        chk("rst_mid_busy_lit", busy, 0);
        chk("rst_mid_idx_lit", frame_idx, 0);
        chk("rst_mid_addr_lit", rom_address, 0);
        chk("rst_mid_in_lit", in_sprite, 0);
        start = 1; step(); start = 0;
        chk("replay_idx_lit", frame_idx, 0);
        for (int t = 1; t <= 6; t++) tick();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
